// File: rtl/lod_pkg.sv
// Shared definitions for the leading-one / leading-sign datapath blocks.
package lod_pkg;

  localparam int unsigned LOD_CNT_W = 32;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  typedef struct packed {
    logic [LOD_CNT_W-1:0] cnt;
    logic                 zero;
  } lod_res_t;

endpackage

// File: rtl/lod_tree.sv
// Combinational recursive leading-zero tree for a power-of-two width W >= 2.
module lod_tree
  import lod_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0]         data_i,
  output logic [clog2(W)-1:0]  cnt_o,
  output logic                 any_o
);

  localparam int unsigned SW = clog2(W);

  generate
    if (W == 2) begin : g_leaf
      assign cnt_o = ~data_i[1];
      assign any_o = |data_i;
    end else begin : g_node
      logic [SW-2:0] cnt_hi;
      logic [SW-2:0] cnt_lo;
      logic          any_hi;
      logic          any_lo;

      lod_tree #(.W(W / 2)) u_hi (
        .data_i (data_i[W-1:W/2]),
        .cnt_o  (cnt_hi),
        .any_o  (any_hi)
      );

      lod_tree #(.W(W / 2)) u_lo (
        .data_i (data_i[W/2-1:0]),
        .cnt_o  (cnt_lo),
        .any_o  (any_lo)
      );

      assign any_o = any_hi | any_lo;
      assign cnt_o = any_hi ? {1'b0, cnt_hi} : {1'b1, cnt_lo};
    end
  endgenerate

endmodule

// File: rtl/lod_norm_pipe.sv
// Two-stage leading-one detector and left normaliser with valid/ready flow control.
// Define LOD_NORM_SIGN_EN to add the in_sign leading-sign (posit regime) mode.
module lod_norm_pipe
  import lod_pkg::*;
#(
  parameter  int unsigned N = 16,
  localparam int unsigned S = clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
`ifdef LOD_NORM_SIGN_EN
  input  logic         in_sign,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [S-1:0] out_cnt,
  output logic         out_zero,
  output logic [N-1:0] out_norm
);

  localparam int unsigned P = 1 << S;

  logic         s1_en, s2_en;
  logic         s1_valid_q, s2_valid_q;
  logic [N-1:0] s1_data_q;
  lod_res_t     s1_res_q, s1_res_d;
  logic         s1_ext_q, s1_ext_d;
  logic [S-1:0] out_cnt_q;
  logic         out_zero_q;
  logic [N-1:0] out_norm_q, s2_norm_d;

  logic [N-1:0] scan;
  logic [P-1:0] scan_pad;
  logic [S-1:0] tree_cnt;
  logic         tree_any;

  assign s2_en    = ~s2_valid_q | out_ready;
  assign s1_en    = ~s1_valid_q | s2_en;
  assign in_ready = s1_en;

  // Sign mode inverts a leading run of ones so the same tree measures the run length.
`ifdef LOD_NORM_SIGN_EN
  assign scan = (in_sign && in_data[N-1]) ? ~in_data : in_data;
`else
  assign scan = in_data;
`endif
  assign scan_pad = P'(scan) << (P - N);

  lod_tree #(.W(P)) u_tree (
    .data_i (scan_pad),
    .cnt_o  (tree_cnt),
    .any_o  (tree_any)
  );

  always_comb begin
    s1_res_d      = '0;
    s1_res_d.zero = ~tree_any;
    s1_res_d.cnt  = tree_any ? LOD_CNT_W'(tree_cnt) : LOD_CNT_W'(N - 1);
    s1_ext_d      = 1'b0;
`ifdef LOD_NORM_SIGN_EN
    if (in_sign) begin
      s1_ext_d = 1'b1;
      if (tree_any) s1_res_d.cnt = LOD_CNT_W'(tree_cnt) - LOD_CNT_W'(1);
    end
`endif
  end

  // Shift amounts at or above 2^S flush to zero; the extra bit covers the sign-mode r = cnt+1.
  always_comb begin
    s2_norm_d = s1_data_q;
    for (int unsigned i = 0; i < S; i++) begin
      if (s1_res_q.cnt[i]) s2_norm_d = s2_norm_d << (1 << i);
    end
    if (|s1_res_q.cnt[LOD_CNT_W-1:S]) s2_norm_d = '0;
    if (s1_ext_q) s2_norm_d = s2_norm_d << 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_res_q   <= '0;
      s1_ext_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      out_cnt_q  <= '0;
      out_zero_q <= 1'b0;
      out_norm_q <= '0;
    end else begin
      if (s1_en) begin
        s1_valid_q <= in_valid;
        s1_data_q  <= in_data;
        s1_res_q   <= s1_res_d;
        s1_ext_q   <= s1_ext_d;
      end
      if (s2_en) begin
        s2_valid_q <= s1_valid_q;
        out_cnt_q  <= s1_res_q.cnt[S-1:0];
        out_zero_q <= s1_res_q.zero;
        out_norm_q <= s2_norm_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_cnt   = out_cnt_q;
  assign out_zero  = out_zero_q;
  assign out_norm  = out_norm_q;

endmodule

// File: tb/tb_lod_norm_pipe.sv
// Self-checking bench: N=16 and N=12 instances against a run-length reference model.
module tb_lod_norm_pipe;

  typedef struct {
    logic [31:0] cnt;
    logic [31:0] zero;
    logic [31:0] norm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        sgn = 1'b0;
  logic [15:0] d16 = '0;
  logic [11:0] d12 = '0;
  logic        rdy16, rdy12, ov16, ov12, oz16, oz12;
  logic [3:0]  oc16, oc12;
  logic [15:0] on16;
  logic [11:0] on12;
  logic        hold = 1'b0;

  int vecs = 0;
  int errs = 0;
  exp_t q16[$];
  exp_t q12[$];

  always #5 clk = ~clk;

  lod_norm_pipe #(.N(16)) u16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (rdy16),
    .in_data   (d16),
`ifdef LOD_NORM_SIGN_EN
    .in_sign   (sgn),
`endif
    .out_valid (ov16),
    .out_ready (out_ready),
    .out_cnt   (oc16),
    .out_zero  (oz16),
    .out_norm  (on16)
  );

  lod_norm_pipe #(.N(12)) u12 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (rdy12),
    .in_data   (d12),
`ifdef LOD_NORM_SIGN_EN
    .in_sign   (sgn),
`endif
    .out_valid (ov12),
    .out_ready (out_ready),
    .out_cnt   (oc12),
    .out_zero  (oz12),
    .out_norm  (on12)
  );

  // Run of bits from the MSB equal to the mode's reference bit (0, or the MSB in sign mode).
  function automatic exp_t model(input logic [15:0] d, input int n, input logic s);
    exp_t e;
    int   r;
    logic m;
    m = s ? d[n-1] : 1'b0;
    r = 0;
    while (r < n && d[n-1-r] == m) r++;
    e.zero = 32'(r == n);
    if (s) begin
      e.cnt  = 32'(r - 1);
      e.norm = (r == n) ? 32'd0 : (32'(d) << r);
    end else begin
      e.cnt  = (r == n) ? 32'(n - 1) : 32'(r);
      e.norm = 32'(d) << e.cnt;
    end
    e.norm = e.norm & ((32'd1 << n) - 32'd1);
    return e;
  endfunction

  function automatic logic [15:0] gen(input int n);
    logic [15:0] v;
    logic [15:0] mask;
    mask = 16'((32'd1 << n) - 32'd1);
    case ($urandom_range(0, 4))
      0:       v = '0;
      1:       v = 16'(32'd1 << $urandom_range(0, n - 1));
      2:       v = 16'($urandom);
      3:       v = 16'($urandom) >> $urandom_range(0, 15);
      default: v = (~(16'($urandom) >> $urandom_range(0, 15))) >> (16 - n);
    endcase
    return v & mask;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    exp_t e;
    @(negedge clk);
    hold = in_valid && !(rdy16 && rdy12);
    if (!rst) begin
      if (in_valid && rdy16) q16.push_back(model(d16, 16, sgn));
      if (in_valid && rdy12) q12.push_back(model({4'b0, d12}, 12, sgn));
      if (ov16 && out_ready) begin
        if (q16.size() == 0) chk("u16_extra", 32'(ov16), 32'd0);
        else begin
          e = q16.pop_front();
          chk("u16_cnt", 32'(oc16), e.cnt);
          chk("u16_zero", 32'(oz16), e.zero);
          chk("u16_norm", 32'(on16), e.norm);
        end
      end
      if (ov12 && out_ready) begin
        if (q12.size() == 0) chk("u12_extra", 32'(ov12), 32'd0);
        else begin
          e = q12.pop_front();
          chk("u12_cnt", 32'(oc12), e.cnt);
          chk("u12_zero", 32'(oz12), e.zero);
          chk("u12_norm", 32'(on12), e.norm);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov16", 32'(ov16), 32'd0);
    chk("rst_cnt16", 32'(oc16), 32'd0);
    chk("rst_zero16", 32'(oz16), 32'd0);
    chk("rst_norm16", 32'(on16), 32'd0);
    chk("rst_ov12", 32'(ov12), 32'd0);
    rst = 1'b0;
    chk("rst_rdy16", 32'(rdy16), 32'd1);

    // Single operand, latency 2
    d16 = 16'h0010; d12 = 12'h001; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("t1_lat1", 32'(ov16), 32'd0);
    cycle();
    chk("t1_lat2", 32'(ov16), 32'd1);
    chk("t1_cnt16", 32'(oc16), 32'd11);
    chk("t1_norm16", 32'(on16), 32'h8000);
    chk("t1_cnt12", 32'(oc12), 32'd11);
    chk("t1_norm12", 32'(on12), 32'h800);
    cycle();

    // Back-to-back zero then MSB-set operand
    d16 = 16'h0000; d12 = 12'h000; in_valid = 1'b1;
    cycle();
    d16 = 16'h8001; d12 = 12'h400;
    cycle();
    in_valid = 1'b0;
    chk("t2_zero16", 32'(oz16), 32'd1);
    chk("t2_cnt16", 32'(oc16), 32'd15);
    chk("t2_norm16", 32'(on16), 32'd0);
    chk("t2_cnt12", 32'(oc12), 32'd11);
    cycle();
    chk("t2b_ov16", 32'(ov16), 32'd1);
    chk("t2b_cnt16", 32'(oc16), 32'd0);
    chk("t2b_norm16", 32'(on16), 32'h8001);
    chk("t2b_cnt12", 32'(oc12), 32'd1);
    cycle();

    // Backpressure
    out_ready = 1'b0; in_valid = 1'b1;
    d16 = 16'h0001; d12 = 12'h001;
    cycle();
    d16 = 16'h0002; d12 = 12'h002;
    cycle();
    d16 = 16'h0004; d12 = 12'h004;
    chk("bp_rdy_drop", 32'(rdy16), 32'd0);
    cycle();
    chk("bp_rdy_hold", 32'(rdy16), 32'd0);
    chk("bp_ov_hold", 32'(ov16), 32'd1);
    chk("bp_cnt_hold", 32'(oc16), 32'd15);
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (3) cycle();
    chk("bp_sb16_empty", 32'(q16.size()), 32'd0);
    chk("bp_sb12_empty", 32'(q12.size()), 32'd0);

    // Asynchronous reset with two operands in flight
    in_valid = 1'b1; d16 = 16'h00F0; d12 = 12'h0F0;
    cycle();
    d16 = 16'h0300; d12 = 12'h030;
    cycle();
    in_valid = 1'b0;
    chk("ar_ov_before", 32'(ov16), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_ov16", 32'(ov16), 32'd0);
    chk("ar_cnt16", 32'(oc16), 32'd0);
    chk("ar_norm16", 32'(on16), 32'd0);
    chk("ar_ov12", 32'(ov12), 32'd0);
    q16.delete();
    q12.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) begin
      cycle();
      chk("ar_stale16", 32'(ov16), 32'd0);
      chk("ar_stale12", 32'(ov12), 32'd0);
    end

`ifdef LOD_NORM_SIGN_EN
    sgn = 1'b1; in_valid = 1'b1;
    d16 = 16'hF3A0; d12 = 12'hF3A;
    cycle();
    d16 = 16'hFFFF; d12 = 12'hFFF;
    cycle();
    in_valid = 1'b0;
    chk("sg_cnt16", 32'(oc16), 32'd3);
    chk("sg_norm16", 32'(on16), 32'h3A00);
    cycle();
    chk("sg_zero16", 32'(oz16), 32'd1);
    chk("sg_cnt16b", 32'(oc16), 32'd15);
    chk("sg_norm16b", 32'(on16), 32'd0);
    cycle();
    sgn = 1'b0;
`endif

    // Randomised traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        d16 = gen(16);
        d12 = 12'(gen(12));
`ifdef LOD_NORM_SIGN_EN
        sgn = 1'($urandom_range(0, 1));
`endif
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cycle();
    chk("end_sb16_empty", 32'(q16.size()), 32'd0);
    chk("end_sb12_empty", 32'(q12.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/lod_norm_pipe.md
Name: lod_norm_pipe

Overview:
- Pipelined, parametrised successor to the combinational leading-one detector.
- Accepts an N-bit operand under valid/ready flow control and returns three results: the leading-zero count, an all-zero flag, and the operand left-normalised so that its leading one sits at the MSB.
- Sits in the posit/float datapath between the decode and the fraction-align logic.
- Two registered stages with full backpressure and no bubbles at throughput 1.

Parameters:
- N, 16, operand width; any value ≥2, including non-powers of two.
- S, clog2(N), count width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand this cycle.
- in_data  in  N  operand.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_cnt  out  S  number of leading zeros from in_data[N-1]; range 0..N-1.
- out_zero  out  1  in_data was all zeros.
- out_norm  out  N  in_data << out_cnt.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: all of s1_valid, s2_valid, out_valid, out_cnt, out_zero and out_norm clear to 0 immediately on rst assertion, independent of clk. Any in-flight transactions are discarded. in_ready = 1 while rst = 0 and the pipeline is empty.
- Transfer rule: a transfer occurs on a rising edge where valid && ready. in_data must be stable while in_valid=1 && in_ready=0. Outputs hold stable while out_valid=1 && out_ready=0.
- Stage 1: registers the operand, the leading-zero count and the zero flag. The count is computed by a recursive halving tree.
- Non-power-of-two N: the operand is padded at the LSB side with zeros up to 2^S. Counts are therefore identical to the unpadded definition.
- Stage 2: registers out_norm = operand << count, a logarithmic barrel shift of S levels. The S1 count and zero flag are forwarded unchanged.
- Latency: 2 cycles from accepted input to out_valid.
- Throughput: 1 per cycle when out_ready=1.
- Stall logic:
  - s2_en = ~s2_valid | out_ready
  - s1_en = ~s1_valid | s2_en
  - in_ready = s1_en
- in_ready is combinational from out_ready. There is no skid buffer.
- Zero operand: out_zero=1, out_cnt=N-1 (saturated), out_norm=0.
- Operand with MSB set: out_cnt=0, out_norm=in_data.
- Operand with only the LSB set: out_cnt=N-1, out_zero=0, out_norm=1<<(N-1).
- Simultaneous events: S2 drain and S1 load in the same cycle are legal, as are S1 advance and a new accept. No data loss or duplication.
- Validity gating: when the corresponding valid is 0, register contents are don't-care but are not X after reset.

Optional Feature:
- Macro: LOD_NORM_SIGN_EN.
- Defined:
  - Adds input port in_sign (1 bit), captured with in_data.
  - in_sign=1 selects leading-sign mode for posit regime decoding:
    - r = run length of bits from MSB equal to in_data[N-1], range 1..N.
    - out_cnt = r-1.
    - out_zero = (r==N).
    - out_norm = in_data << r, and equals 0 when r=N.
  - in_sign=0 gives exactly the default behaviour.
  - Latency and handshake are unchanged.
- Undefined: no in_sign port; leading-one mode only.

Decomposition:
- Shared package lod_pkg contains:
  - a clog2 constant function;
  - a typedef for the {cnt, zero} result pair, used by the normaliser and the posit decode.
- One sub-module, lod_tree, holds the combinational recursive leading-zero/valid tree for the power-of-two width. lod_norm_pipe instantiates it once in stage 1.
- The barrel shifter stays inline.

Test Plan:
- N=16, out_ready=1, in_data=16'h0010 -> 2 cycles later out_valid=1, out_cnt=11, out_zero=0, out_norm=16'h8000.
- N=16, in_data=16'h0000 then 16'h8001 back-to-back -> consecutive cycles:
  - first result: out_cnt=15, out_zero=1, out_norm=0;
  - second result: out_cnt=0, out_norm=16'h8001.
- Backpressure: stream 16'h0001, 16'h0002, 16'h0004 and hold out_ready=0 for 3 cycles:
  - in_ready drops after 2 accepts;
  - after release, results arrive in order with out_cnt 15, 14, 13 and no loss or duplicates.
- N=12 (non-power-of-two): in_data=12'h001 -> out_cnt=11, out_norm=12'h800; in_data=12'h400 -> out_cnt=1.
- Assert rst mid-stream with 2 transactions in flight -> out_valid=0 in the same cycle (asynchronous). After release, no stale result emerges.
- With LOD_NORM_SIGN_EN, N=16, in_sign=1:
  - in_data=16'hF3A0 -> out_cnt=3, out_norm=16'h3A00;
  - in_data=16'hFFFF -> out_zero=1, out_cnt=15, out_norm=0.
